// File: rtl/fault_trigger_sequencer.sv
// ============================================================================
// fault_trigger_sequencer: counts trigger pulses and issues them as spaced, gate_ready-qualified fault pulses.
// Optional feature macro: FAULT_TRIG_STATS_EN (issued-pulse counter). Revision: 1.0
// ============================================================================
`default_nettype none

module fault_trigger_sequencer #(
  parameter int SRC_COUNT = 4,
  parameter int CNT_W     = 4,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 logic_reset,
  input  logic [SRC_COUNT-1:0] trig_in,
  input  logic                 gate_ready,
  output logic                 fault_out,
  output logic [CNT_W-1:0]     pending,
  output logic                 busy,
  output logic                 overflow,
  output logic [15:0]          issued_cnt
);

  localparam int ADD_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT + 1) : 1;
  localparam int SUM_W = CNT_W + $clog2(SRC_COUNT) + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CNT_W-1:0] PEND_MAX   = '1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic             fault_q,   fault_d;
  logic             ovf_q,     ovf_d;

  logic [ADD_W-1:0] add_w;
  logic [SUM_W-1:0] sum_w;
  logic             sat_w;
  logic             issue_w;
  logic [CNT_W-1:0] pend_next_w;

  always_comb begin
    add_w = '0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      add_w = add_w + ADD_W'(trig_in[i]);
    end
  end

  // The issue decision and the decrement share an edge, so pending never counts a pulse already on fault_out.
  assign issue_w = (state_q == ST_ISSUE) && (gap_q == '0) && gate_ready &&
                   (pending_q != '0) && !logic_reset;

  assign sum_w       = SUM_W'(pending_q) + SUM_W'(add_w) - SUM_W'(issue_w);
  assign sat_w       = (sum_w > SUM_W'(PEND_MAX)) && !logic_reset;
  assign pend_next_w = sat_w ? PEND_MAX : sum_w[CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    pending_d = pend_next_w;
    fault_d   = 1'b0;
    ovf_d     = ovf_q | sat_w;
    gap_d     = (gap_q != '0) ? (gap_q - GAP_W'(1)) : gap_q;

    case (state_q)
      ST_IDLE: begin
        if (add_w != '0) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_w) begin
          fault_d = 1'b1;
          gap_d   = GAP_RELOAD;
          if (pend_next_w == '0) begin
            state_d = ST_IDLE;
          end
        end else if (gap_q == '0 && !gate_ready) begin
          state_d = ST_WAIT;
        end else if (pending_q == '0 && add_w == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (gate_ready) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame abort drops everything in flight, including this cycle's arrivals.
    if (logic_reset) begin
      state_d   = ST_IDLE;
      pending_d = '0;
      gap_d     = '0;
      fault_d   = 1'b0;
      ovf_d     = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      gap_q     <= '0;
      fault_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      fault_q   <= fault_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef FAULT_TRIG_STATS_EN
  logic [15:0] issued_q, issued_d;

  assign issued_d = issue_w ? (issued_q + 16'd1) : issued_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q <= 16'h0000;
    end else begin
      issued_q <= issued_d;
    end
  end

  assign issued_cnt = issued_q;
`else
  assign issued_cnt = 16'h0000;
`endif

  assign fault_out = fault_q;
  assign pending   = pending_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = ovf_q;

endmodule

`default_nettype wire
